ct_f_spsram_arb: RTL and testbench

Two-port round-robin arbiter and sequencer for one single-port SRAM macro of the `ct_f_spsram_*` family (default 32768x128). It accepts read and write requests from two independent requesters over valid/ready handshakes and drives the macro's active-low `CEN`/`GWEN`/`WEN` controls. It returns read data through a per-port registered response slot with backpressure. It sits between cache/buffer control logic and the SRAM wrapper, and is the only block allowed to drive the macro's pins.

---
 rtl/ct_f_spsram_arb.sv | 132 +++++++++++++
 tb/tb_ct_f_spsram_arb.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_f_spsram_arb.sv
// Two-requester round-robin arbiter and sequencer for one single-port SRAM macro.
// Drives the macro's active-low controls and returns read data through per-port response slots.
module ct_f_spsram_arb #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  CLK,
    input  logic                  RST,

    input  logic                  req_vld_p0,
    output logic                  req_rdy_p0,
    input  logic                  req_wr_p0,
    input  logic [ADDR_WIDTH-1:0] req_addr_p0,
    input  logic [DATA_WIDTH-1:0] req_wdata_p0,
    input  logic [DATA_WIDTH-1:0] req_wmask_p0,

    input  logic                  req_vld_p1,
    output logic                  req_rdy_p1,
    input  logic                  req_wr_p1,
    input  logic [ADDR_WIDTH-1:0] req_addr_p1,
    input  logic [DATA_WIDTH-1:0] req_wdata_p1,
    input  logic [DATA_WIDTH-1:0] req_wmask_p1,

    output logic                  rsp_vld_p0,
    input  logic                  rsp_rdy_p0,
    output logic [DATA_WIDTH-1:0] rsp_data_p0,

    output logic                  rsp_vld_p1,
    input  logic                  rsp_rdy_p1,
    output logic [DATA_WIDTH-1:0] rsp_data_p1,

    output logic [ADDR_WIDTH-1:0] A,
    output logic                  CEN,
    output logic                  GWEN,
    output logic [DATA_WIDTH-1:0] WEN,
    output logic [DATA_WIDTH-1:0] D,
    input  logic [DATA_WIDTH-1:0] Q
);

    logic                  rr_ptr_q, rr_ptr_d;
    logic                  pend_vld_q, pend_vld_d;
    logic                  pend_id_q, pend_id_d;
    logic                  rsp_vld_p0_q, rsp_vld_p0_d;
    logic                  rsp_vld_p1_q, rsp_vld_p1_d;
    logic [DATA_WIDTH-1:0] rsp_data_p0_q, rsp_data_p0_d;
    logic [DATA_WIDTH-1:0] rsp_data_p1_q, rsp_data_p1_d;

    logic rd_ok_p0, rd_ok_p1;
    logic elig_p0, elig_p1;
    logic gnt_p0, gnt_p1, any_gnt;
    logic win_wr;
    logic cap_p0, cap_p1;

    // A read may only launch when its response slot will be free by the time Q arrives.
    assign rd_ok_p0 = !(pend_vld_q && !pend_id_q) && (!rsp_vld_p0_q || rsp_rdy_p0);
    assign rd_ok_p1 = !(pend_vld_q &&  pend_id_q) && (!rsp_vld_p1_q || rsp_rdy_p1);

    assign elig_p0 = req_vld_p0 && (req_wr_p0 || rd_ok_p0) && !RST;
    assign elig_p1 = req_vld_p1 && (req_wr_p1 || rd_ok_p1) && !RST;

    assign gnt_p0  = elig_p0 && (!elig_p1 || !rr_ptr_q);
    assign gnt_p1  = elig_p1 && (!elig_p0 ||  rr_ptr_q);
    assign any_gnt = gnt_p0 || gnt_p1;
    assign win_wr  = gnt_p1 ? req_wr_p1 : req_wr_p0;

    assign req_rdy_p0 = gnt_p0;
    assign req_rdy_p1 = gnt_p1;

    assign cap_p0 = pend_vld_q && !pend_id_q;
    assign cap_p1 = pend_vld_q &&  pend_id_q;

    always_comb begin
        A    = '0;
        CEN  = 1'b1;
        GWEN = 1'b1;
        WEN  = '1;
        D    = '0;
        if (any_gnt) begin
            CEN = 1'b0;
            A   = gnt_p1 ? req_addr_p1 : req_addr_p0;
            if (win_wr) begin
                GWEN = 1'b0;
                WEN  = gnt_p1 ? ~req_wmask_p1 : ~req_wmask_p0;
                D    = gnt_p1 ? req_wdata_p1 : req_wdata_p0;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_p0) begin
            rr_ptr_d = 1'b1;
        end else if (gnt_p1) begin
            rr_ptr_d = 1'b0;
        end

        pend_vld_d = any_gnt && !win_wr;
        pend_id_d  = gnt_p1;

        // A capture into a slot being drained at the same edge reloads it and keeps it valid.
        rsp_vld_p0_d  = cap_p0 || (rsp_vld_p0_q && !rsp_rdy_p0);
        rsp_vld_p1_d  = cap_p1 || (rsp_vld_p1_q && !rsp_rdy_p1);
        rsp_data_p0_d = cap_p0 ? Q : rsp_data_p0_q;
        rsp_data_p1_d = cap_p1 ? Q : rsp_data_p1_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_ptr_q      <= 1'b0;
            pend_vld_q    <= 1'b0;
            pend_id_q     <= 1'b0;
            rsp_vld_p0_q  <= 1'b0;
            rsp_vld_p1_q  <= 1'b0;
            rsp_data_p0_q <= '0;
            rsp_data_p1_q <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            pend_vld_q    <= pend_vld_d;
            pend_id_q     <= pend_id_d;
            rsp_vld_p0_q  <= rsp_vld_p0_d;
            rsp_vld_p1_q  <= rsp_vld_p1_d;
            rsp_data_p0_q <= rsp_data_p0_d;
            rsp_data_p1_q <= rsp_data_p1_d;
        end
    end

    assign rsp_vld_p0  = rsp_vld_p0_q;
    assign rsp_vld_p1  = rsp_vld_p1_q;
    assign rsp_data_p0 = rsp_data_p0_q;
    assign rsp_data_p1 = rsp_data_p1_q;

endmodule

// File: tb/tb_ct_f_spsram_arb.sv
// Bench for ct_f_spsram_arb: behavioural SRAM on the macro pins, reference memory,
// per-port expected-response queues and directed stimulus.
module tb_ct_f_spsram_arb;

    localparam int AW = 15;
    localparam int DW = 128;

    logic          CLK = 1'b0;
    logic          RST;
    logic          req_vld_p0, req_rdy_p0, req_wr_p0;
    logic [AW-1:0] req_addr_p0;
    logic [DW-1:0] req_wdata_p0, req_wmask_p0;
    logic          req_vld_p1, req_rdy_p1, req_wr_p1;
    logic [AW-1:0] req_addr_p1;
    logic [DW-1:0] req_wdata_p1, req_wmask_p1;
    logic          rsp_vld_p0, rsp_rdy_p0;
    logic [DW-1:0] rsp_data_p0;
    logic          rsp_vld_p1, rsp_rdy_p1;
    logic [DW-1:0] rsp_data_p1;
    logic [AW-1:0] A;
    logic          CEN, GWEN;
    logic [DW-1:0] WEN, D, Q;

    int test_cnt = 0;
    int fail_cnt = 0;

    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];
    logic [DW-1:0] ref_mem[logic [AW-1:0]];
    logic [DW-1:0] sram_mem[logic [AW-1:0]];
    logic [DW-1:0] q_r = '0;

    ct_f_spsram_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RST(RST),
        .req_vld_p0(req_vld_p0), .req_rdy_p0(req_rdy_p0), .req_wr_p0(req_wr_p0),
        .req_addr_p0(req_addr_p0), .req_wdata_p0(req_wdata_p0), .req_wmask_p0(req_wmask_p0),
        .req_vld_p1(req_vld_p1), .req_rdy_p1(req_rdy_p1), .req_wr_p1(req_wr_p1),
        .req_addr_p1(req_addr_p1), .req_wdata_p1(req_wdata_p1), .req_wmask_p1(req_wmask_p1),
        .rsp_vld_p0(rsp_vld_p0), .rsp_rdy_p0(rsp_rdy_p0), .rsp_data_p0(rsp_data_p0),
        .rsp_vld_p1(rsp_vld_p1), .rsp_rdy_p1(rsp_rdy_p1), .rsp_data_p1(rsp_data_p1),
        .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .D(D), .Q(Q)
    );

    // Clock / behavioural SRAM
    always #5 CLK = ~CLK;
    assign Q = q_r;

    function automatic logic [DW-1:0] sram_rd(input logic [AW-1:0] a);
        return sram_mem.exists(a) ? sram_mem[a] : '0;
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    always @(posedge CLK) begin
        if (CEN === 1'b0) begin
            if (GWEN === 1'b0) sram_mem[A] = (sram_rd(A) & WEN) | (D & ~WEN);
            else               q_r <= sram_rd(A);
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        test_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_grant(input string tag, input logic wr, input logic [AW-1:0] a,
                               input logic [DW-1:0] wd, input logic [DW-1:0] wm);
        check({tag, "_cen"}, CEN, 1'b0);
        check({tag, "_a"}, A, a);
        check({tag, "_gwen"}, GWEN, !wr);
        check({tag, "_wen"}, WEN, wr ? ~wm : {DW{1'b1}});
        check({tag, "_d"}, D, wr ? wd : '0);
    endtask

    // Scoreboard: pop on response handshake, then record accepted requests.
    always @(negedge CLK) begin
        if (RST === 1'b1) begin
            exp_q0.delete();
            exp_q1.delete();
            check("rst_rdy", {req_rdy_p1, req_rdy_p0}, 2'b00);
            check("rst_cen", CEN, 1'b1);
            check("rst_gwen", GWEN, 1'b1);
            check("rst_wen", WEN, {DW{1'b1}});
        end else begin
            if (rsp_vld_p0 && rsp_rdy_p0) begin
                check("p0_rsp_expected", exp_q0.size() != 0, 1'b1);
                if (exp_q0.size() != 0) check("p0_rsp_data", rsp_data_p0, exp_q0.pop_front());
            end
            if (rsp_vld_p1 && rsp_rdy_p1) begin
                check("p1_rsp_expected", exp_q1.size() != 0, 1'b1);
                if (exp_q1.size() != 0) check("p1_rsp_data", rsp_data_p1, exp_q1.pop_front());
            end
            check("one_grant", req_rdy_p0 && req_rdy_p1, 1'b0);
            if (req_rdy_p0) begin
                check("p0_gnt_vld", req_vld_p0, 1'b1);
                check_grant("p0_gnt", req_wr_p0, req_addr_p0, req_wdata_p0, req_wmask_p0);
                if (req_wr_p0)
                    ref_mem[req_addr_p0] = (ref_rd(req_addr_p0) & ~req_wmask_p0) | (req_wdata_p0 & req_wmask_p0);
                else
                    exp_q0.push_back(ref_rd(req_addr_p0));
            end else if (req_rdy_p1) begin
                check("p1_gnt_vld", req_vld_p1, 1'b1);
                check_grant("p1_gnt", req_wr_p1, req_addr_p1, req_wdata_p1, req_wmask_p1);
                if (req_wr_p1)
                    ref_mem[req_addr_p1] = (ref_rd(req_addr_p1) & ~req_wmask_p1) | (req_wdata_p1 & req_wmask_p1);
                else
                    exp_q1.push_back(ref_rd(req_addr_p1));
            end else begin
                check("idle_cen", CEN, 1'b1);
                check("idle_gwen", GWEN, 1'b1);
                check("idle_wen", WEN, {DW{1'b1}});
                check("idle_a", A, '0);
                check("idle_d", D, '0);
            end
        end
    end

    // Driver tasks
    task automatic drive(input bit p, input logic v, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [DW-1:0] wm);
        if (p) begin
            req_vld_p1 = v; req_wr_p1 = wr; req_addr_p1 = a; req_wdata_p1 = wd; req_wmask_p1 = wm;
        end else begin
            req_vld_p0 = v; req_wr_p0 = wr; req_addr_p0 = a; req_wdata_p0 = wd; req_wmask_p0 = wm;
        end
    endtask

    // Holds a request until accepted; returns just after the edge that ends the accept cycle.
    task automatic issue(input bit p, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [DW-1:0] wm);
        logic ok;
        ok = 1'b0;
        drive(p, 1'b1, wr, a, wd, wm);
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge CLK);
            ok = p ? req_rdy_p1 : req_rdy_p0;
            @(posedge CLK); #1;
        end
        drive(p, 1'b0, 1'b0, '0, '0, '0);
        check("issue_ack", ok, 1'b1);
    endtask

    task automatic wait_rsp(input bit p, input logic [DW-1:0] exp);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge CLK);
            seen = p ? rsp_vld_p1 : rsp_vld_p0;
            if (seen) check("wait_rsp_data", p ? rsp_data_p1 : rsp_data_p0, exp);
            @(posedge CLK); #1;
        end
        check("wait_rsp_seen", seen, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK); #1;
        end
    endtask

    logic [DW-1:0] pat;

    initial begin
        RST = 1'b1;
        rsp_rdy_p0 = 1'b1;
        rsp_rdy_p1 = 1'b1;
        drive(0, 1'b1, 1'b1, 15'h1, '1, '1);
        drive(1, 1'b1, 1'b1, 15'h2, '1, '1);

        // Reset with both requesters pushing: nothing may be granted.
        @(posedge CLK); #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("rst_rsp_vld", {rsp_vld_p1, rsp_vld_p0}, 2'b00);
            check("rst_rsp_data0", rsp_data_p0, '0);
            check("rst_rsp_data1", rsp_data_p1, '0);
            @(posedge CLK); #1;
        end
        RST = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        idle(2);

        // Full-mask write then read, with exact read latency.
        issue(0, 1'b1, 15'h10, {16{8'hA5}}, '1);
        issue(0, 1'b0, 15'h10, '0, '0);
        @(negedge CLK);
        check("rd_lat_t1", rsp_vld_p0, 1'b0);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("rd_lat_t2", rsp_vld_p0, 1'b1);
        check("rd_data_a5", rsp_data_p0, {16{8'hA5}});
        @(posedge CLK); #1;

        // Masked write of zeros over all-ones, read back from the other port.
        issue(0, 1'b1, 15'h20, '1, '1);
        issue(0, 1'b1, 15'h20, '0, {{(DW-8){1'b0}}, 8'hFF});
        issue(1, 1'b0, 15'h20, '0, '0);
        wait_rsp(1, {{(DW-8){1'b1}}, 8'h00});

        // All-zero mask write must leave memory unchanged.
        issue(1, 1'b1, 15'h20, '0, '0);
        issue(0, 1'b0, 15'h20, '0, '0);
        wait_rsp(0, {{(DW-8){1'b1}}, 8'h00});

        // Random single-port traffic over a small address window.
        for (int i = 0; i < 12; i++) begin
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                  {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        end
        idle(4);

        // Stalled p1 response: p1 reads blocked, p0 writes flow every cycle.
        pat = {4{32'h1234_5678}};
        issue(1, 1'b1, 15'h30, pat, '1);
        issue(1, 1'b1, 15'h31, ~pat, '1);
        rsp_rdy_p1 = 1'b0;
        issue(1, 1'b0, 15'h30, '0, '0);
        @(posedge CLK); #1;
        for (int i = 0; i < 5; i++) begin
            drive(1, 1'b1, 1'b0, 15'h31, '0, '0);
            drive(0, 1'b1, 1'b1, AW'(15'h40 + i), {$urandom, $urandom, $urandom, $urandom}, '1);
            @(negedge CLK);
            check("stall_vld", rsp_vld_p1, 1'b1);
            check("stall_data", rsp_data_p1, pat);
            check("stall_p1_blocked", req_rdy_p1, 1'b0);
            check("stall_p0_flows", req_rdy_p0, 1'b1);
            @(posedge CLK); #1;
        end
        rsp_rdy_p1 = 1'b1;
        drive(0, 1'b1, 1'b1, 15'h45, '0, '1);
        @(negedge CLK);
        check("drain_p1_accept", req_rdy_p1, 1'b1);
        check("drain_p0_wait", req_rdy_p0, 1'b0);
        @(posedge CLK); #1;
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        wait_rsp(1, ~pat);
        idle(3);

        // Reset in the cycle after a read accept: the read is dropped.
        issue(0, 1'b0, 15'h10, '0, '0);
        RST = 1'b1;
        @(negedge CLK);
        check("rst_mid_vld", rsp_vld_p0, 1'b0);
        @(posedge CLK); #1;
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("rst_drop_vld", {rsp_vld_p1, rsp_vld_p0}, 2'b00);
            @(posedge CLK); #1;
        end

        // Continuous writes from both ports: p0 first after reset, then alternate.
        drive(0, 1'b1, 1'b1, 15'h50, {16{8'h5A}}, '1);
        drive(1, 1'b1, 1'b1, 15'h51, {16{8'hC3}}, '1);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            check("alt_wr_p0", req_rdy_p0, (i % 2 == 0));
            check("alt_wr_p1", req_rdy_p1, (i % 2 == 1));
            @(posedge CLK); #1;
        end

        // Continuous reads from both ports sustain one access per cycle.
        drive(0, 1'b1, 1'b0, 15'h50, '0, '0);
        drive(1, 1'b1, 1'b0, 15'h51, '0, '0);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            check("alt_rd_p0", req_rdy_p0, (i % 2 == 0));
            check("alt_rd_p1", req_rdy_p1, (i % 2 == 1));
            @(posedge CLK); #1;
        end
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        idle(5);

        check("q0_drained", exp_q0.size(), '0);
        check("q1_drained", exp_q1.size(), '0);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
